// File: rtl/decoder_3_8_pulse_if.sv
// Handshake and one-hot output bundle for decoder_3_8_pulse.
// master drives codes and enable, slave (the decoder) returns ready, one-hot lines and status.
interface decoder_3_8_pulse_if;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] code;
    logic [7:0] y;
    logic [2:0] active_code;
    logic       busy;
    logic       done;

    modport master (
        output enable,
        output in_valid,
        output code,
        input  in_ready,
        input  y,
        input  active_code,
        input  busy,
        input  done
    );

    modport slave (
        input  enable,
        input  in_valid,
        input  code,
        output in_ready,
        output y,
        output active_code,
        output busy,
        output done
    );
endinterface

// File: rtl/decoder_3_8_pulse.sv
// Registered 3-to-8 decoder: an accepted code drives its one-hot line for HOLD_CYCLES cycles, then pulses done.
// One-hot visible the cycle after accept; in_ready is low for the whole hold, and enable low aborts to idle.
module decoder_3_8_pulse #(
    parameter int HOLD_CYCLES = 4   // legal range 1..255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_3_8_pulse_if.slave   bus
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    y_q, y_nxt;
    logic [2:0]    act_q, act_nxt;
    logic          done_q, done_nxt;
    logic          rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            y_q    <= 8'h00;
            act_q  <= 3'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            y_q    <= y_nxt;
            act_q  <= act_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        y_nxt     = y_q;
        act_nxt   = act_q;
        done_nxt  = 1'b0;
        if (!bus.enable) begin
            // Abort beats a completing hold: no done, active_code retained.
            state_nxt = IDLE;
            cnt_nxt   = '0;
            y_nxt     = 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && rdy) begin
                        state_nxt = HOLD;
                        cnt_nxt   = CNT_LOAD;
                        y_nxt     = 8'd1 << bus.code;
                        act_nxt   = bus.code;
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        y_nxt     = 8'h00;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    y_nxt     = 8'h00;
                end
            endcase
        end
    end

    always_comb begin
        rdy             = (state == IDLE) && bus.enable;
        bus.in_ready    = rdy;
        bus.busy        = (state == HOLD);
        bus.y           = y_q;
        bus.active_code = act_q;
        bus.done        = done_q;
    end

endmodule

// File: tb/tb_decoder_3_8_pulse.sv
// Scoreboard bench for decoder_3_8_pulse: one HOLD_CYCLES=4 and one HOLD_CYCLES=1 instance share stimulus,
// a remaining-cycles reference model predicts each cycle's outputs and a negedge monitor compares them.
module tb_decoder_3_8_pulse;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decoder_3_8_pulse_if bus4();
    decoder_3_8_pulse_if bus1();

    decoder_3_8_pulse #(.HOLD_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    decoder_3_8_pulse #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] ac;
        logic       busy;
        logic       done;
        logic       rdy;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    // Model state: cycles of visible one-hot still owed, code shown, last accepted code, done pending.
    int         hc[2] = '{4, 1};
    int         hl[2] = '{0, 0};
    logic [2:0] mc[2] = '{3'd0, 3'd0};
    logic [2:0] ma[2] = '{3'd0, 3'd0};
    logic       md[2] = '{1'b0, 1'b0};

    logic       cur_rn   = 1'b0;
    logic       cur_en   = 1'b0;
    logic       cur_vld  = 1'b0;
    logic [2:0] cur_code = 3'd0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input int d, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, d, cyc, got, exp);
    endtask

    function automatic exp_t predict(input int d);
        exp_t e;
        e.y    = (hl[d] > 0) ? (8'd1 << mc[d]) : 8'h00;
        e.ac   = ma[d];
        e.busy = (hl[d] > 0);
        e.done = md[d];
        e.rdy  = (hl[d] == 0) && cur_en;
        return e;
    endfunction

    task automatic model_edge(input int d);
        if (!cur_rn) begin
            hl[d] = 0; md[d] = 1'b0; ma[d] = 3'd0;
        end else if (!cur_en) begin
            hl[d] = 0; md[d] = 1'b0;
        end else if (hl[d] == 0) begin
            md[d] = 1'b0;
            if (cur_vld) begin
                hl[d] = hc[d]; mc[d] = cur_code; ma[d] = cur_code;
            end
        end else if (hl[d] == 1) begin
            hl[d] = 0; md[d] = 1'b1;
        end else begin
            hl[d] = hl[d] - 1;
        end
    endtask

    task automatic drive_bus(input logic en, input logic vld, input logic [2:0] c);
        bus4.enable = en; bus4.in_valid = vld; bus4.code = c;
        bus1.enable = en; bus1.in_valid = vld; bus1.code = c;
    endtask

    task automatic step(input logic rn, input logic en, input logic vld, input logic [2:0] c);
        @(posedge clk);
        #1;
        cyc++;
        model_edge(0);
        model_edge(1);
        cur_rn = rn; cur_en = en; cur_vld = vld; cur_code = c;
        rst_n = rn;
        drive_bus(en, vld, c);
        if (!rn) begin
            for (int d = 0; d < 2; d++) begin
                hl[d] = 0; md[d] = 1'b0; ma[d] = 3'd0;
            end
        end
        q4.push_back(predict(0));
        q1.push_back(predict(1));
    endtask

    task automatic compare(input int d, input exp_t e, input logic [7:0] y, input logic [2:0] ac,
                           input logic busy, input logic done, input logic rdy);
        chk("y", d, y, e.y);
        chk("active_code", d, 8'(ac), 8'(e.ac));
        chk("busy", d, 8'(busy), 8'(e.busy));
        chk("done", d, 8'(done), 8'(e.done));
        chk("in_ready", d, 8'(rdy), 8'(e.rdy));
        chk("onehot", d, 8'($countones(y) <= 1), 8'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            compare(0, e, bus4.y, bus4.active_code, bus4.busy, bus4.done, bus4.in_ready);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            compare(1, e, bus1.y, bus1.active_code, bus1.busy, bus1.done, bus1.in_ready);
        end
    end

    initial begin
        drive_bus(1'b0, 1'b0, 3'd0);

        // Power-on reset with a valid code presented.
        repeat (3) step(1'b0, 1'b1, 1'b1, 3'd5);

        // Back-to-back sweep, each code held until the done cycle accepts the next.
        for (int c = 0; c < 8; c++)
            repeat (5) step(1'b1, 1'b1, 1'b1, 3'(c));
        repeat (3) step(1'b1, 1'b1, 1'b0, 3'd0);

        // Code 2 waits behind a hold of code 5.
        step(1'b1, 1'b1, 1'b1, 3'd5);
        repeat (6) step(1'b1, 1'b1, 1'b1, 3'd2);
        repeat (6) step(1'b1, 1'b1, 1'b0, 3'd0);

        // Abort in the second hold cycle; requests stay blocked while disabled.
        step(1'b1, 1'b1, 1'b1, 3'd3);
        step(1'b1, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        repeat (3) step(1'b1, 1'b0, 1'b1, 3'd6);
        repeat (3) step(1'b1, 1'b1, 1'b0, 3'd0);

        // Enable falls in the last hold cycle.
        step(1'b1, 1'b1, 1'b1, 3'd1);
        repeat (3) step(1'b1, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 3'd0);

        // Reset mid-hold with in_valid high.
        step(1'b1, 1'b1, 1'b1, 3'd6);
        repeat (2) step(1'b1, 1'b1, 1'b0, 3'd0);
        repeat (2) step(1'b0, 1'b1, 1'b1, 3'd4);
        repeat (3) step(1'b1, 1'b1, 1'b0, 3'd0);

        // Randomized traffic with occasional aborts and resets.
        repeat (400) begin
            step(1'($urandom_range(0, 79) != 0),
                 1'($urandom_range(0, 11) != 0),
                 1'($urandom_range(0, 2) != 0),
                 3'($urandom_range(0, 7)));
        end

        repeat (2) step(1'b1, 1'b1, 1'b0, 3'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("drain", 0, 8'(q4.size() + q1.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
